if_fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage pipeline: program counter, PC+4 incrementer, branch-target mux, instruction ROM and the IF/ID pipeline register. Each cycle it fetches the word at the current PC and presents {PC+4, instruction} both combinationally and registered to the decode stage. The hazard unit drives freeze; the execute stage drives branch redirect and flush.

---
 rtl/if_fetch_unit.sv | 73 +++++++
 tb/tb_if_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, PC+4 incrementer, branch redirect,
// combinational instruction ROM and the IF/ID pipeline register.
module if_fetch_unit #(
  parameter int          MEM_WORDS = 64,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        Branch_taken,
  input  logic [31:0] BranchAddr,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Reg,
  output logic [31:0] Instruction_Reg
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   pc_q;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;
  logic [AW-1:0] rom_idx;
  logic          rom_hit;
  logic [31:0]   rom_word;

  // Byte-offset bits of both addresses are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{BranchAddr[1:0], pc_q[1:0]};

  assign pc_plus4 = pc_q + 32'd4;
  assign rom_idx  = pc_q[AW+1:2];
  assign rom_hit  = (pc_q[31:AW+2] == '0);

  assign rom_word = 32'hE3A0_0000 + 32'(rom_idx);

  // Addresses beyond the ROM read as zero instead of aliasing.
  always_comb begin
    pc_next     = pc_plus4;
    PC          = pc_plus4;
    Instruction = rom_hit ? rom_word : 32'h0000_0000;
    if (freeze) begin
      pc_next = pc_q;
    end else if (Branch_taken) begin
      pc_next = {BranchAddr[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Flush has priority over freeze so a stalled slot can still be bubbled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_Reg          <= 32'h0000_0000;
      Instruction_Reg <= 32'h0000_0000;
    end else if (flush) begin
      PC_Reg          <= 32'h0000_0000;
      Instruction_Reg <= 32'h0000_0000;
    end else if (!freeze) begin
      PC_Reg          <= PC;
      Instruction_Reg <= Instruction;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural fetch model checked every cycle, plus
// hand-computed literal expectations along the directed sequence.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [31:0] PC_Reg;
    logic [31:0] Instruction_Reg;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    if_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .flush(flush),
        .Branch_taken(Branch_taken),
        .BranchAddr(BranchAddr),
        .PC(PC),
        .Instruction(Instruction),
        .PC_Reg(PC_Reg),
        .Instruction_Reg(Instruction_Reg)
    );

    // Clock and reset
    initial clk = 0;
    always #5 clk = ~clk;

    // Model: fetch address, and the IF/ID contents as a {pc+4, word} pair
    logic [31:0] m_pc;
    logic [31:0] m_pc_reg;
    logic [31:0] m_ir;

    function automatic logic [31:0] rom_model(input logic [31:0] addr);
        if (addr < 32'd256) return 32'hE3A0_0000 + (addr / 4);
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc     <= 32'h0;
            m_pc_reg <= 32'h0;
            m_ir     <= 32'h0;
        end else begin
            if (flush) begin
                m_pc_reg <= 32'h0;
                m_ir     <= 32'h0;
            end else if (!freeze) begin
                m_pc_reg <= m_pc + 32'd4;
                m_ir     <= rom_model(m_pc);
            end
            if (!freeze) m_pc <= Branch_taken ? (BranchAddr & 32'hFFFF_FFFC) : m_pc + 32'd4;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Single compare process against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("model_pc", PC, m_pc + 32'd4);
            check("model_instr", Instruction, rom_model(m_pc));
            check("model_pc_reg", PC_Reg, m_pc_reg);
            check("model_instr_reg", Instruction_Reg, m_ir);
        end
    end

    // Driver tasks
    task automatic drive(input logic fz, input logic fl, input logic bt, input logic [31:0] ba);
        freeze       = fz;
        flush        = fl;
        Branch_taken = bt;
        BranchAddr   = ba;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input string tag, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] pr, input logic [31:0] ir);
        check({tag, "_pc"}, PC, p);
        check({tag, "_instr"}, Instruction, i);
        check({tag, "_pc_reg"}, PC_Reg, pr);
        check({tag, "_instr_reg"}, Instruction_Reg, ir);
    endtask

    typedef struct {
        logic        fz;
        logic        fl;
        logic        bt;
        logic [31:0] ba;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst = 0;
        drive(0, 0, 0, 32'h0);
        #2;
        pin("reset", 32'h4, 32'hE3A0_0000, 32'h0, 32'h0);

        @(negedge clk);
        #1;
        rst = 1;
        check_en = 1;
        cyc(3);
        pin("seq3", 32'h10, 32'hE3A0_0003, 32'hC, 32'hE3A0_0002);

        drive(0, 0, 1, 32'h20);
        cyc(1);
        pin("branch20", 32'h24, 32'hE3A0_0008, 32'h10, 32'hE3A0_0003);
        drive(0, 0, 1, 32'h23);
        cyc(1);
        pin("branch23", 32'h24, 32'hE3A0_0008, 32'h24, 32'hE3A0_0008);

        drive(1, 0, 1, 32'h40);
        cyc(2);
        pin("freeze", 32'h24, 32'hE3A0_0008, 32'h24, 32'hE3A0_0008);
        drive(0, 0, 0, 32'h0);
        cyc(1);
        pin("unfreeze", 32'h28, 32'hE3A0_0009, 32'h24, 32'hE3A0_0008);

        drive(0, 1, 0, 32'h0);
        cyc(1);
        pin("flush", 32'h2C, 32'hE3A0_000A, 32'h0, 32'h0);
        drive(0, 0, 0, 32'h0);
        cyc(1);
        drive(1, 1, 0, 32'h0);
        cyc(1);
        pin("flush_frz", 32'h30, 32'hE3A0_000B, 32'h0, 32'h0);

        drive(0, 0, 1, 32'h100);
        cyc(1);
        pin("oob", 32'h104, 32'h0, 32'h30, 32'hE3A0_000B);
        drive(0, 0, 1, 32'hFC);
        cyc(1);
        pin("last", 32'h100, 32'hE3A0_003F, 32'h104, 32'h0);
        drive(0, 0, 1, 32'hFFFF_FFFC);
        cyc(1);
        check("wrap_pc", PC, 32'h0);
        check("wrap_instr", Instruction, 32'h0);
        drive(0, 0, 0, 32'h0);
        cyc(1);
        pin("wrapped", 32'h4, 32'hE3A0_0000, 32'h0, 32'h0);

        // Mixed directed vectors, checked by the model only
        vecs[0] = '{0, 0, 0, 32'h0};
        vecs[1] = '{0, 0, 1, 32'h84};
        vecs[2] = '{1, 0, 0, 32'h0};
        vecs[3] = '{0, 1, 1, 32'h0C};
        vecs[4] = '{1, 1, 1, 32'h50};
        vecs[5] = '{0, 0, 0, 32'h0};
        vecs[6] = '{0, 0, 1, 32'hF8};
        vecs[7] = '{0, 0, 0, 32'h0};
        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].fz, vecs[k].fl, vecs[k].bt, vecs[k].ba);
            cyc(1);
        end
        drive(0, 0, 0, 32'h0);
        cyc(2);

        // Reset asserted between edges takes effect at once
        #2;
        rst = 0;
        #1;
        pin("midreset", 32'h4, 32'hE3A0_0000, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        rst = 1;
        cyc(2);
        pin("after_rst", 32'hC, 32'hE3A0_0002, 32'h8, 32'hE3A0_0001);

        cyc(1);
        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
